alu_rs: RTL
===========

# alu_rs

Reservation station feeding the combinational ALU in the Tomasulo core. Holds issued ALU-class instructions (LUI … AND, jumps, branches), snoops the two result broadcast buses (ALU and load/store buffer) to wake up pending operands, and each cycle dispatches the lowest-index ready entry into registered ALU input ports. It is the producer on the ALU's input side; ALU outputs are broadcast back into it.

## Interface
- RS_SIZE, 8: number of entries; power of two; index width RS_IDX_W = log2(RS_SIZE).
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  core ready; low = pause
- clear_in  input  1  mispredict flush, synchronous
- issue_valid  input  1  issue one instruction this cycle
- issue_opt  input  `OPT_RANGE  opcode; 0 never issued
- issue_vj, issue_vk  input  32  operand values
- issue_qj_busy, issue_qk_busy  input  1  operand pending
- issue_qj, issue_qk  input  `ROB_RANGE  producing ROB tag
- issue_imm, issue_pc  input  32  immediate, instruction PC
- issue_rob  input  `ROB_RANGE  destination ROB tag
- full_out  output  1  no free entry
- alu_cdb_valid  input  1  ALU broadcast valid (ALU result_valid)
- alu_cdb_rob  input  `ROB_RANGE; alu_cdb_val  input  32
- lsb_cdb_valid  input  1; lsb_cdb_rob  input  `ROB_RANGE; lsb_cdb_val  input  32
- alu_opt  output  `OPT_RANGE  dispatched opcode, 0 = bubble
- alu_rs1, alu_rs2, alu_imm, alu_pc  output  32  dispatched operands
- alu_rob  output  `ROB_RANGE  dispatched destination tag

## Operation
- Per entry: busy, opt, vj, vk, qj_busy, qk_busy, qj, qk, imm, pc, rob.
- Reset (rst_in low, any time, async): all busy cleared; all ALU outputs 0; full_out 0.
- full_out = all entries busy (registered busy bits only, conservative; same-cycle dispatch not credited).
- Issue: when issue_valid and not full_out, write lowest-index free entry. issue_valid while full_out is a protocol error (bench asserts it never happens); entry is not written.
- Issue-time forwarding: if issue_qj_busy and a valid CDB in the same cycle carries issue_qj, store its value and clear qj_busy; same for qk. ALU bus checked before LSB bus (both matching the same tag is illegal).
- Wake-up: every busy entry with qj_busy and matching valid CDB tag captures the value and clears qj_busy; likewise qk. Both operands may wake on the same cycle from different buses.
- Ready = busy and not qj_busy and not qk_busy (registered state only).
- Dispatch: lowest-index ready entry is loaded into alu_* registers and its busy cleared. No ready entry: alu_opt loads 0, other alu_* hold.
- Priority: rst_in > clear_in > rdy_in low > normal. clear_in: all busy cleared, alu_opt 0, issue ignored that cycle. rdy_in low: entries and forwarding frozen (CDB inputs ignored), alu_opt loads 0 so the ALU emits no duplicate result.
- Freed entry is reusable by issue in the next cycle, not the same one.

## Timing
- Issue with ready operands at edge k: entry busy after k; ALU inputs valid after edge k+1; ALU result on CDB during cycle k+1..k+2 combinationally. Issue-to-ALU latency 2 edges.
- CDB wake-up in cycle c: entry becomes ready after edge c, dispatch at edge c+1.
- One issue and one dispatch per cycle maximum; throughput 1/cycle when operands ready.
- alu_opt is 0 for exactly every cycle without a dispatch; never held across two cycles for the same entry.

## Structure
- Add to utils.v: `RS_SIZE, `RS_RANGE (entry index range); reuse `OPT_RANGE, `ROB_RANGE, `DATA_RANGE and opcode defines.
- One sub-module, rs_prio_enc: RS_SIZE-bit request vector -> found flag + lowest set index. Instantiated twice (free select, ready select).

## Test plan
- Reset: hold rst_in low mid-run with 3 busy entries -> after release full_out 0, alu_opt 0, next issue lands in entry 0.
- Ready ADD issue (vj=5, vk=7, rob=3) at edge 0 -> after edge 1 alu_opt=`ADD, rs1=5, rs2=7, alu_rob=3; next cycle alu_opt=0.
- Pending operand: ADDI qj=2 issued, alu_cdb rob=2 val=0x10 two cycles later -> dispatch one edge after broadcast with alu_rs1=0x10; same-cycle issue+broadcast of tag 2 -> dispatched 2 edges after issue.
- Fill: issue RS_SIZE entries all pending on tag 9 -> full_out 1; broadcast lsb tag 9 val 1 -> entries dispatched in index order, one per cycle, full_out drops after first dispatch.
- clear_in with 4 busy entries and a simultaneous issue -> next cycle full_out 0, alu_opt 0, no dispatch ever from flushed entries.
- rdy_in low 3 cycles with ready entry and CDB broadcast -> alu_opt 0, broadcast not captured; after rdy_in high, ready entry dispatches.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg
// Shared sizes, opcode encodings and the entry record for the ALU reservation
// station. No ports; imported by alu_rs and rs_prio_enc.
package alu_rs_pkg;

   localparam int RS_SIZE  = 8;
   localparam int RS_IDX_W = $clog2(RS_SIZE);
   localparam int OPT_W    = 6;
   localparam int ROB_W    = 4;
   localparam int DATA_W   = 32;

   // Opcode 0 is never issued and doubles as the "no dispatch" bubble marker.
   localparam logic [OPT_W-1:0] OPT_NOP   = 6'd0;
   localparam logic [OPT_W-1:0] OPT_LUI   = 6'd1;
   localparam logic [OPT_W-1:0] OPT_AUIPC = 6'd2;
   localparam logic [OPT_W-1:0] OPT_JAL   = 6'd3;
   localparam logic [OPT_W-1:0] OPT_JALR  = 6'd4;
   localparam logic [OPT_W-1:0] OPT_BEQ   = 6'd5;
   localparam logic [OPT_W-1:0] OPT_BNE   = 6'd6;
   localparam logic [OPT_W-1:0] OPT_BLT   = 6'd7;
   localparam logic [OPT_W-1:0] OPT_BGE   = 6'd8;
   localparam logic [OPT_W-1:0] OPT_BLTU  = 6'd9;
   localparam logic [OPT_W-1:0] OPT_BGEU  = 6'd10;
   localparam logic [OPT_W-1:0] OPT_ADDI  = 6'd11;
   localparam logic [OPT_W-1:0] OPT_SLTI  = 6'd12;
   localparam logic [OPT_W-1:0] OPT_SLTIU = 6'd13;
   localparam logic [OPT_W-1:0] OPT_XORI  = 6'd14;
   localparam logic [OPT_W-1:0] OPT_ORI   = 6'd15;
   localparam logic [OPT_W-1:0] OPT_ANDI  = 6'd16;
   localparam logic [OPT_W-1:0] OPT_SLLI  = 6'd17;
   localparam logic [OPT_W-1:0] OPT_SRLI  = 6'd18;
   localparam logic [OPT_W-1:0] OPT_SRAI  = 6'd19;
   localparam logic [OPT_W-1:0] OPT_ADD   = 6'd20;
   localparam logic [OPT_W-1:0] OPT_SUB   = 6'd21;
   localparam logic [OPT_W-1:0] OPT_SLL   = 6'd22;
   localparam logic [OPT_W-1:0] OPT_SLT   = 6'd23;
   localparam logic [OPT_W-1:0] OPT_SLTU  = 6'd24;
   localparam logic [OPT_W-1:0] OPT_XOR   = 6'd25;
   localparam logic [OPT_W-1:0] OPT_SRL   = 6'd26;
   localparam logic [OPT_W-1:0] OPT_SRA   = 6'd27;
   localparam logic [OPT_W-1:0] OPT_OR    = 6'd28;
   localparam logic [OPT_W-1:0] OPT_AND   = 6'd29;

   // One reservation-station slot. qj_busy/qk_busy mean the operand is still
   // waiting for the ROB entry named by qj/qk to broadcast its result.
   typedef struct packed {
      logic              busy;
      logic [OPT_W-1:0]  opt;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic              qj_busy;
      logic              qk_busy;
      logic [ROB_W-1:0]  qj;
      logic [ROB_W-1:0]  qk;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [ROB_W-1:0]  rob;
   } rs_entry_t;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// rs_prio_enc
// Lowest-index-first priority encoder over the reservation-station entries.
// Ports:
//   req   - one request bit per entry
//   found - at least one request bit is set
//   idx   - index of the lowest set request bit (0 when none)
module rs_prio_enc
   import alu_rs_pkg::*;
(
   input  logic [RS_SIZE-1:0]  req,
   output logic                found,
   output logic [RS_IDX_W-1:0] idx
);

   // Scanning from the top down lets the lowest set bit overwrite last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = i[RS_IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// alu_rs
// Reservation station in front of the combinational ALU. Holds issued
// ALU-class instructions, snoops the ALU and load/store result buses to wake
// pending operands, and each cycle dispatches the lowest-index ready entry
// into the registered ALU input ports.
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (low = pause), clear_in (flush)
//   issue_*        - one incoming instruction per cycle, qualified by issue_valid
//   full_out       - every entry is occupied
//   alu_cdb_*      - ALU result broadcast
//   lsb_cdb_*      - load/store buffer result broadcast
//   alu_opt..alu_rob - registered ALU inputs; alu_opt == 0 marks a bubble
module alu_rs
   import alu_rs_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_in,

   input  logic              issue_valid,
   input  logic [OPT_W-1:0]  issue_opt,
   input  logic [DATA_W-1:0] issue_vj,
   input  logic [DATA_W-1:0] issue_vk,
   input  logic              issue_qj_busy,
   input  logic              issue_qk_busy,
   input  logic [ROB_W-1:0]  issue_qj,
   input  logic [ROB_W-1:0]  issue_qk,
   input  logic [DATA_W-1:0] issue_imm,
   input  logic [DATA_W-1:0] issue_pc,
   input  logic [ROB_W-1:0]  issue_rob,
   output logic              full_out,

   input  logic              alu_cdb_valid,
   input  logic [ROB_W-1:0]  alu_cdb_rob,
   input  logic [DATA_W-1:0] alu_cdb_val,
   input  logic              lsb_cdb_valid,
   input  logic [ROB_W-1:0]  lsb_cdb_rob,
   input  logic [DATA_W-1:0] lsb_cdb_val,

   output logic [OPT_W-1:0]  alu_opt,
   output logic [DATA_W-1:0] alu_rs1,
   output logic [DATA_W-1:0] alu_rs2,
   output logic [DATA_W-1:0] alu_imm,
   output logic [DATA_W-1:0] alu_pc,
   output logic [ROB_W-1:0]  alu_rob
);

   rs_entry_t entries [RS_SIZE];

   logic [RS_SIZE-1:0]  busy_vec;
   logic [RS_SIZE-1:0]  ready_vec;
   logic                free_found;
   logic [RS_IDX_W-1:0] free_idx;
   logic                ready_found;
   logic [RS_IDX_W-1:0] ready_idx;

   logic [DATA_W-1:0]   fwd_vj;
   logic [DATA_W-1:0]   fwd_vk;
   logic                fwd_qj_busy;
   logic                fwd_qk_busy;

   // Occupancy and readiness come from registered state only, so an entry
   // woken or dispatched this cycle is not credited until the next one.
   always_comb begin
      busy_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_vec[i]  = entries[i].busy;
         ready_vec[i] = entries[i].busy && !entries[i].qj_busy && !entries[i].qk_busy;
      end
   end

   assign full_out = &busy_vec;

   rs_prio_enc u_free_enc (
      .req   (~busy_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   rs_prio_enc u_ready_enc (
      .req   (ready_vec),
      .found (ready_found),
      .idx   (ready_idx)
   );

   // Issue-time forwarding catches a producer broadcasting in the same cycle
   // its consumer is issued; the ALU bus takes precedence over the LSB bus.
   always_comb begin
      fwd_vj      = issue_vj;
      fwd_qj_busy = issue_qj_busy;
      fwd_vk      = issue_vk;
      fwd_qk_busy = issue_qk_busy;
      if (issue_qj_busy) begin
         if (alu_cdb_valid && alu_cdb_rob == issue_qj) begin
            fwd_vj      = alu_cdb_val;
            fwd_qj_busy = 1'b0;
         end else if (lsb_cdb_valid && lsb_cdb_rob == issue_qj) begin
            fwd_vj      = lsb_cdb_val;
            fwd_qj_busy = 1'b0;
         end
      end
      if (issue_qk_busy) begin
         if (alu_cdb_valid && alu_cdb_rob == issue_qk) begin
            fwd_vk      = alu_cdb_val;
            fwd_qk_busy = 1'b0;
         end else if (lsb_cdb_valid && lsb_cdb_rob == issue_qk) begin
            fwd_vk      = lsb_cdb_val;
            fwd_qk_busy = 1'b0;
         end
      end
   end

   // Entry storage and the ALU input registers. A flush drops every entry;
   // a pause freezes everything but still emits a bubble so the ALU never
   // repeats a result. Otherwise wake-up, dispatch and issue happen together:
   // they never touch the same entry because issue only targets free slots,
   // wake-up only busy ones, and dispatch only fully ready ones.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries[i] <= '0;
         end
         alu_opt <= OPT_NOP;
         alu_rs1 <= '0;
         alu_rs2 <= '0;
         alu_imm <= '0;
         alu_pc  <= '0;
         alu_rob <= '0;
      end else if (clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries[i].busy <= 1'b0;
         end
         alu_opt <= OPT_NOP;
      end else if (!rdy_in) begin
         alu_opt <= OPT_NOP;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (entries[i].busy && entries[i].qj_busy) begin
               if (alu_cdb_valid && alu_cdb_rob == entries[i].qj) begin
                  entries[i].vj      <= alu_cdb_val;
                  entries[i].qj_busy <= 1'b0;
               end else if (lsb_cdb_valid && lsb_cdb_rob == entries[i].qj) begin
                  entries[i].vj      <= lsb_cdb_val;
                  entries[i].qj_busy <= 1'b0;
               end
            end
            if (entries[i].busy && entries[i].qk_busy) begin
               if (alu_cdb_valid && alu_cdb_rob == entries[i].qk) begin
                  entries[i].vk      <= alu_cdb_val;
                  entries[i].qk_busy <= 1'b0;
               end else if (lsb_cdb_valid && lsb_cdb_rob == entries[i].qk) begin
                  entries[i].vk      <= lsb_cdb_val;
                  entries[i].qk_busy <= 1'b0;
               end
            end
         end

         if (ready_found) begin
            alu_opt                 <= entries[ready_idx].opt;
            alu_rs1                 <= entries[ready_idx].vj;
            alu_rs2                 <= entries[ready_idx].vk;
            alu_imm                 <= entries[ready_idx].imm;
            alu_pc                  <= entries[ready_idx].pc;
            alu_rob                 <= entries[ready_idx].rob;
            entries[ready_idx].busy <= 1'b0;
         end else begin
            alu_opt <= OPT_NOP;
         end

         if (issue_valid && free_found) begin
            entries[free_idx] <= '{busy:    1'b1,
                                   opt:     issue_opt,
                                   vj:      fwd_vj,
                                   vk:      fwd_vk,
                                   qj_busy: fwd_qj_busy,
                                   qk_busy: fwd_qk_busy,
                                   qj:      issue_qj,
                                   qk:      issue_qk,
                                   imm:     issue_imm,
                                   pc:      issue_pc,
                                   rob:     issue_rob};
         end
      end
   end

endmodule
